// File: rtl/feistel_lfsr_round_core_if.sv
// feistel_lfsr_round_core_if: block-in / result-out bundle for the Feistel round core
// master (input stage side): drives left_in, right_in, trigger, key_seed; sees data_out, valid, busy, overrun
// slave  (core side):        sees left_in, right_in, trigger, key_seed; drives data_out, valid, busy, overrun
interface feistel_lfsr_round_core_if;
    logic [31:0] left_in;
    logic [31:0] right_in;
    logic [31:0] key_seed;
    logic        trigger;
    logic [63:0] data_out;
    logic        valid;
    logic        busy;
    logic        overrun;
    modport master(output left_in, right_in, trigger, key_seed, input data_out, valid, busy, overrun);
    modport slave(input left_in, right_in, trigger, key_seed, output data_out, valid, busy, overrun);
endinterface

// File: rtl/feistel_lfsr_round_core.sv
// feistel_lfsr_round_core: multi-cycle Feistel cipher core, one round per clock, LFSR subkeys
// Ports: clk (rising edge), rst (asynchronous, active-low),
//        bus (slave): left_in/right_in halves, trigger start pulse, key_seed LFSR seed,
//                     data_out {R_final, L_final}, valid pulse, busy, sticky overrun.
// Optional macro LFSR_CHAIN_EN: seed is loaded only on the first accepted trigger after
// reset; later blocks continue the keystream from the current LFSR state.
module feistel_lfsr_round_core #(
    parameter int          NUM_ROUNDS = 16,
    parameter logic [31:0] LFSR_TAPS  = 32'h80200003
) (
    input logic clk,
    input logic rst,
    feistel_lfsr_round_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    localparam logic [6:0] LAST = 7'(NUM_ROUNDS - 1);
    state_t      state;
    logic [6:0]  round_cnt;
    logic [31:0] l_q, r_q, lfsr;
    logic [31:0] mix, f, r_new, lfsr_next, seed, lfsr_load;
    logic [63:0] data_q;
    logic        valid_q, busy_q, overrun_q;
    always_comb begin
        mix       = r_q ^ lfsr;
        f         = {mix[28:0], mix[31:29]} + lfsr;
        r_new     = l_q ^ f;
        lfsr_next = lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
        // an all-zero Galois LFSR never leaves zero, so a zero seed becomes 1
        seed      = (bus.key_seed == '0) ? 32'h1 : bus.key_seed;
    end
`ifdef LFSR_CHAIN_EN
    logic seed_loaded;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            seed_loaded <= 1'b0;
        else if (state == IDLE && bus.trigger)
            seed_loaded <= 1'b1;
    end
    assign lfsr_load = seed_loaded ? lfsr : seed;
`else
    assign lfsr_load = seed;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            round_cnt <= '0;
            l_q       <= '0;
            r_q       <= '0;
            lfsr      <= 32'h1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.trigger) begin
                    l_q       <= bus.left_in;
                    r_q       <= bus.right_in;
                    lfsr      <= lfsr_load;
                    round_cnt <= '0;
                    busy_q    <= 1'b1;
                    state     <= ROUND;
                end
                ROUND: begin
                    l_q       <= r_q;
                    r_q       <= r_new;
                    lfsr      <= lfsr_next;
                    round_cnt <= round_cnt + 7'd1;
                    if (round_cnt == LAST) begin
                        // final swap: output {R_new, L_new} where L_new is the old R
                        data_q  <= {r_new, r_q};
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
            if (bus.trigger && state != IDLE)
                overrun_q <= 1'b1;
        end
    end
    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_feistel_lfsr_round_core.sv
// tb_feistel_lfsr_round_core: self-checking bench for feistel_lfsr_round_core (1-round and 16-round instances)
module tb_feistel_lfsr_round_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] m_lfsr = 32'h1;
    logic        m_loaded = 1'b0;
    always #5 clk = ~clk;
    feistel_lfsr_round_core_if b1();
    feistel_lfsr_round_core_if b16();
    feistel_lfsr_round_core #(.NUM_ROUNDS(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    feistel_lfsr_round_core #(.NUM_ROUNDS(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] seed;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[7];
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic [31:0] l0, input logic [31:0] r0,
                                          input logic [31:0] k0, input int n,
                                          output logic [31:0] k_out);
        logic [31:0] l, r, k, x, t;
        l = l0;
        r = r0;
        k = k0;
        for (int i = 0; i < n; i++) begin
            x = r ^ k;
            t = l ^ ({x[28:0], x[31:29]} + k);
            l = r;
            r = t;
            k = k[0] ? ((k >> 1) ^ 32'h80200003) : (k >> 1);
        end
        k_out = k;
        return {r, l};
    endfunction
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_loaded = 1'b0;
    endtask
    // one 16-round block; optional dropped trigger at edge T+inj; mid = data_out after edge T+8
    task automatic run_block(input string name, input logic [31:0] l, input logic [31:0] r,
                             input logic [31:0] s, input int inj,
                             output logic [63:0] got, output logic [63:0] mid);
        logic [31:0] k0, kf;
        logic [63:0] exp;
        int vat, vcnt, bcnt;
        k0 = (s == 0) ? 32'h1 : s;
`ifdef LFSR_CHAIN_EN
        if (m_loaded) k0 = m_lfsr;
`endif
        m_loaded = 1'b1;
        exp = model(l, r, k0, 16, kf);
        m_lfsr = kf;
        b16.left_in = l;
        b16.right_in = r;
        b16.key_seed = s;
        b16.trigger = 1'b1;
        @(posedge clk); #1;
        b16.trigger = 1'b0;
        bcnt = int'(b16.busy);
        vat = 0;
        vcnt = 0;
        got = '0;
        mid = '0;
        for (int i = 1; i <= 20; i++) begin
            if (i == inj) begin
                b16.trigger = 1'b1;
                b16.left_in = ~l;
                b16.right_in = ~r;
                b16.key_seed = s + 32'h1234;
            end
            @(posedge clk); #1;
            b16.trigger = 1'b0;
            bcnt += int'(b16.busy);
            if (i == 8) mid = b16.data_out;
            if (b16.valid) begin
                vcnt++;
                vat = i;
                got = b16.data_out;
            end
        end
        check({name, " valid_edge"}, 64'(vat), 64'd16);
        check({name, " valid_count"}, 64'(vcnt), 64'd1);
        check({name, " busy_cycles"}, 64'(bcnt), 64'd17);
        check({name, " data"}, got, exp);
    endtask
    initial begin
        logic [63:0] d1, d2, prev, mid;
        int vcnt;
        vecs[0] = '{32'h00000000, 32'h00000000, 32'h00000000, 64'h00000009_00000000};
        vecs[1] = '{32'h12345678, 32'h00000000, 32'h00000001, 64'h12345671_00000000};
        vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
        vecs[3] = '{32'hAAAAAAAA, 32'h00000001, 32'h00000002, 64'hAAAAAAB0_00000001};
        vecs[4] = '{32'h00000000, 32'h00000000, 32'h80000000, 64'h80000004_00000000};
        vecs[5] = '{32'h00000000, 32'h20000000, 32'hE0000000, 64'hE0000006_20000000};
        vecs[6] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 64'hFFFFFFFE_00000000};
        b1.left_in = '0; b1.right_in = '0; b1.key_seed = '0; b1.trigger = 1'b0;
        b16.left_in = '0; b16.right_in = '0; b16.key_seed = '0; b16.trigger = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset u1 outputs", {b1.data_out}, 64'h0);
        check("reset u1 flags", {61'h0, b1.valid, b1.busy, b1.overrun}, 64'h0);
        check("reset u16 outputs", b16.data_out, 64'h0);
        check("reset u16 flags", {61'h0, b16.valid, b16.busy, b16.overrun}, 64'h0);
        rst = 1'b1;
        for (int v = 0; v < 7; v++) begin
            do_reset();
            b1.left_in = vecs[v].l;
            b1.right_in = vecs[v].r;
            b1.key_seed = vecs[v].seed;
            b1.trigger = 1'b1;
            @(posedge clk); #1;
            b1.trigger = 1'b0;
            check($sformatf("n1 v%0d start flags", v), {62'h0, b1.valid, b1.busy}, 64'h1);
            @(posedge clk); #1;
            check($sformatf("n1 v%0d flags", v), {62'h0, b1.valid, b1.busy}, 64'h3);
            check($sformatf("n1 v%0d data", v), b1.data_out, vecs[v].exp);
            @(posedge clk); #1;
            check($sformatf("n1 v%0d end flags", v), {62'h0, b1.valid, b1.busy}, 64'h0);
            check($sformatf("n1 v%0d hold", v), b1.data_out, vecs[v].exp);
        end
        run_block("blk16a", $urandom, $urandom, $urandom, 0, d1, mid);
        check("hold after valid", b16.data_out, d1);
        check("no overrun yet", {63'h0, b16.overrun}, 64'h0);
        prev = d1;
        run_block("overrun", $urandom, $urandom, $urandom, 5, d1, mid);
        check("hold during rounds", mid, prev);
        check("overrun set", {63'h0, b16.overrun}, 64'h1);
        repeat (3) @(posedge clk);
        #1 check("overrun sticky", {63'h0, b16.overrun}, 64'h1);
        b16.left_in = 32'hDEADBEEF;
        b16.right_in = 32'hCAFEF00D;
        b16.key_seed = 32'h00C0FFEE;
        b16.trigger = 1'b1;
        @(posedge clk); #1;
        b16.trigger = 1'b0;
        vcnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            vcnt += int'(b16.valid);
        end
        rst = 1'b0;
        #1;
        check("async reset data", b16.data_out, 64'h0);
        check("async reset flags", {61'h0, b16.valid, b16.busy, b16.overrun}, 64'h0);
        b16.trigger = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            vcnt += int'(b16.valid);
        end
        rst = 1'b1;
        b16.trigger = 1'b0;
        m_loaded = 1'b0;
        check("no valid for aborted block", 64'(vcnt), 64'd0);
        @(posedge clk); #1;
        check("trigger at reset release ignored", {62'h0, b16.busy, b16.overrun}, 64'h0);
        run_block("after reset", 32'h01234567, 32'h89ABCDEF, 32'h0, 0, d1, mid);
        run_block("same seed 1", 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h13579BDF, 0, d1, mid);
        run_block("same seed 2", 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h13579BDF, 0, d2, mid);
`ifdef LFSR_CHAIN_EN
        check("chained blocks differ", {63'h0, d2 != d1}, 64'h1);
`else
        check("same seed same data", d2, d1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
